// File: rtl/spi_slave_port.sv
// SPI mode-0 slave with an Avalon-style 16-bit register port; SPI pins are oversampled in clk.
// Optional build macro SPIS_LSBFIRST_EN switches the shifter to LSB-first; the default is MSB-first.
module spi_slave_port #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] UNDERRUN_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    localparam logic [15:0] CTRL_MASK = 16'h01DC;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;

    state_t      r_state;
    logic [7:0]  r_shift_reg;
    logic [2:0]  r_bit_cnt;
    logic        r_byte_done;
    logic        r_miso;
    logic        r_miso_oe;
    logic [7:0]  r_tx_holding;
    logic        r_primed;
    logic [7:0]  r_rx_holding;
    logic        r_rrdy;
    logic        r_roe;
    logic        r_toe;
    logic        r_und;
    logic [15:0] r_control;
    logic        r_access_prev;
    logic [15:0] r_data_to_cpu;
    logic        r_irq;

    logic        w_sclk_s;
    logic        w_ss_s;
    logic        w_mosi_s;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_ss_fall;
    logic        w_access;
    logic        w_rd_stb;
    logic        w_wr_stb;
    logic        w_wr_tx;
    logic        w_wr_status;
    logic        w_wr_ctrl;
    logic        w_rd_rx;
    logic [7:0]  w_load_byte;
    logic [7:0]  w_shift_next;
    logic        w_first_bit;
    logic        w_present_bit;
    logic [15:0] w_status;

    // NOTE: every flop here resets asynchronously on reset_n low, so MISO is released mid-frame at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_prev <= w_sclk_s;
            r_ss_prev   <= w_ss_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev & ~w_ss_s;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev & ~w_ss_s;
    assign w_ss_fall   = r_ss_prev & ~w_ss_s;

    // Only the first cycle of a held access is a strobe.
    assign w_access    = spi_select & (~read_n | ~write_n);
    assign w_rd_stb    = w_access & ~r_access_prev & ~read_n;
    assign w_wr_stb    = w_access & ~r_access_prev & ~write_n;
    assign w_wr_tx     = w_wr_stb & (mem_addr == 3'd1);
    assign w_wr_status = w_wr_stb & (mem_addr == 3'd2);
    assign w_wr_ctrl   = w_wr_stb & (mem_addr == 3'd3);
    assign w_rd_rx     = w_rd_stb & (mem_addr == 3'd0);

    assign w_load_byte = r_primed ? r_tx_holding : UNDERRUN_BYTE;

`ifdef SPIS_LSBFIRST_EN
    assign w_shift_next  = {w_mosi_s, r_shift_reg[7:1]};
    assign w_first_bit   = w_load_byte[0];
    assign w_present_bit = r_shift_reg[0];
`else
    assign w_shift_next  = {r_shift_reg[6:0], w_mosi_s};
    assign w_first_bit   = w_load_byte[7];
    assign w_present_bit = r_shift_reg[7];
`endif

    assign w_status = {6'b0, ~w_ss_s, (r_roe | r_toe | r_und), r_rrdy, ~r_primed,
                       1'b0, r_toe, r_roe, r_und, 2'b00};

    // Status clears come first and set events later in the block, so a coincident set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_shift_reg  <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_byte_done  <= 1'b0;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_tx_holding <= 8'h00;
            r_primed     <= 1'b0;
            r_rx_holding <= 8'h00;
            r_rrdy       <= 1'b0;
            r_roe        <= 1'b0;
            r_toe        <= 1'b0;
            r_und        <= 1'b0;
            r_control    <= 16'h0000;
        end else begin
            if (w_wr_status) begin
                r_roe  <= 1'b0;
                r_toe  <= 1'b0;
                r_und  <= 1'b0;
                r_rrdy <= 1'b0;
            end
            if (w_rd_rx)
                r_rrdy <= 1'b0;
            if (w_wr_ctrl)
                r_control <= data_from_cpu & CTRL_MASK;

            if (w_ss_s) begin
                r_state     <= ST_IDLE;
                r_bit_cnt   <= 3'd0;
                r_byte_done <= 1'b0;
                r_miso      <= 1'b0;
                r_miso_oe   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_fall)
                            r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        r_shift_reg <= w_load_byte;
                        if (r_primed)
                            r_primed <= 1'b0;
                        else
                            r_und <= 1'b1;
                        r_bit_cnt   <= 3'd0;
                        r_byte_done <= 1'b0;
                        r_miso      <= w_first_bit;
                        r_miso_oe   <= 1'b1;
                        r_state     <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_sclk_rise) begin
                            r_shift_reg <= w_shift_next;
                            r_bit_cnt   <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_rx_holding <= w_shift_next;
                                if (r_rrdy)
                                    r_roe <= 1'b1;
                                r_rrdy      <= 1'b1;
                                r_byte_done <= 1'b1;
                            end
                        end else if (w_sclk_fall) begin
                            if (r_byte_done)
                                r_state <= ST_LOAD;
                            else
                                r_miso <= w_present_bit;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            // r_primed here is the pre-LOAD value, so a write racing LOAD sees the old TRDY.
            if (w_wr_tx) begin
                if (r_primed) begin
                    r_toe <= 1'b1;
                end else begin
                    r_tx_holding <= data_from_cpu[7:0];
                    r_primed     <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_access_prev <= 1'b0;
            r_data_to_cpu <= 16'h0000;
            r_irq         <= 1'b0;
        end else begin
            r_access_prev <= w_access;
            r_irq         <= |(w_status & r_control);
            if (w_rd_stb) begin
                case (mem_addr)
                    3'd0:    r_data_to_cpu <= {8'h00, r_rx_holding};
                    3'd2:    r_data_to_cpu <= w_status;
                    3'd3:    r_data_to_cpu <= r_control;
                    default: r_data_to_cpu <= 16'h0000;
                endcase
            end
        end
    end

    assign MISO          = r_miso;
    assign MISO_oe       = r_miso_oe;
    assign data_to_cpu   = r_data_to_cpu;
    assign irq           = r_irq;
    assign dataavailable = r_rrdy;
    assign readyfordata  = ~r_primed;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: an SPI master model at f_clk/16 plus CPU register accesses.
module tb_spi_slave_port;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        SCLK;
    logic        SS_n;
    logic        MOSI;
    logic        MISO;
    logic        MISO_oe;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       prime;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[4];

    spi_slave_port dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .SCLK          (SCLK),
        .SS_n          (SS_n),
        .MOSI          (MOSI),
        .MISO          (MISO),
        .MISO_oe       (MISO_oe),
        .spi_select    (spi_select),
        .mem_addr      (mem_addr),
        .read_n        (read_n),
        .write_n       (write_n),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .irq           (irq),
        .dataavailable (dataavailable),
        .readyfordata  (readyfordata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        @(posedge clk); #1;
        @(posedge clk); #1;
        spi_select = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(posedge clk); #1;
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        @(posedge clk); #1;
        d = data_to_cpu;
        @(posedge clk); #1;
        spi_select = 1'b0; read_n = 1'b1;
    endtask

    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            MOSI = mo[i];
            repeat (HALF) @(posedge clk);
            #1;
            mi[i] = MISO;
            SCLK = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            SCLK = 1'b0;
        end
    endtask

    task automatic ss_close();
        repeat (HALF) @(posedge clk);
        #1;
        SS_n = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic frame1(input logic [7:0] mo, output logic [7:0] mi);
        SS_n = 1'b0;
        spi_xfer(mo, 8, mi);
        ss_close();
    endtask

    task automatic frame2(input logic [7:0] mo0, input logic [7:0] mo1,
                          output logic [7:0] mi0, output logic [7:0] mi1);
        SS_n = 1'b0;
        spi_xfer(mo0, 8, mi0);
        spi_xfer(mo1, 8, mi1);
        ss_close();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;
        logic [7:0]  mi;
        logic [7:0]  mi2;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 8'hC3, 8'h00};
        vecs[2] = '{1'b1, 8'h81, 8'h00, 8'h81};
        vecs[3] = '{1'b1, 8'hFF, 8'h7E, 8'hFF};

        reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
        mem_addr = 3'd0; data_from_cpu = 16'h0000;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        check("rst_miso", {15'b0, MISO}, 16'h0000);
        check("rst_miso_oe", {15'b0, MISO_oe}, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        check("rst_readyfordata", {15'b0, readyfordata}, 16'h0001);
        check("rst_dataavailable", {15'b0, dataavailable}, 16'h0000);
        check("rst_data_to_cpu", data_to_cpu, 16'h0000);
        cpu_read(3'd2, d);
        check("rst_status", d, 16'h0040);

        // Single-byte frames from the vector table.
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].prime)
                cpu_write(3'd1, {8'h00, vecs[v].tx});
            frame1(vecs[v].mosi, mi);
            check($sformatf("vec%0d_miso", v), {8'h00, mi}, {8'h00, vecs[v].exp_miso});
            check($sformatf("vec%0d_rrdy", v), {15'b0, dataavailable}, 16'h0001);
            cpu_read(3'd0, d);
            check($sformatf("vec%0d_rxdata", v), d, {8'h00, vecs[v].mosi});
            check($sformatf("vec%0d_rrdy_clr", v), {15'b0, dataavailable}, 16'h0000);
        end

        // Control masking, unmapped read, underrun with UND interrupt enabled.
        cpu_write(3'd3, 16'hFFFF);
        cpu_read(3'd3, d);
        check("ctrl_mask", d, 16'h01DC);
        check("irq_trdy", {15'b0, irq}, 16'h0001);
        cpu_read(3'd5, d);
        check("unmapped_read", d, 16'h0000);
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd3, 16'h0004);
        repeat (2) @(posedge clk);
        #1;
        check("irq_cleared", {15'b0, irq}, 16'h0000);
        frame1(8'h5E, mi);
        check("und_miso", {8'h00, mi}, 16'h0000);
        cpu_read(3'd2, d);
        check("und_status", d, 16'h01C4);
        check("und_irq", {15'b0, irq}, 16'h0001);

        // Two bytes without reading rxdata -> overrun.
        cpu_write(3'd2, 16'h0000);
        frame2(8'h11, 8'h22, mi, mi2);
        cpu_read(3'd2, d);
        check("roe_status", d, 16'h01CC);
        cpu_read(3'd0, d);
        check("roe_rxdata", d, 16'h0022);
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, d);
        check("status_cleared", d, 16'h0040);
        check("irq_after_clear", {15'b0, irq}, 16'h0000);

        // Double txdata write -> TOE, first value transmitted.
        cpu_write(3'd1, 16'h0096);
        cpu_write(3'd1, 16'h003F);
        check("toe_trdy", {15'b0, readyfordata}, 16'h0000);
        cpu_read(3'd2, d);
        check("toe_status", d, 16'h0110);
        frame1(8'h55, mi);
        check("toe_miso", {8'h00, mi}, 16'h0096);
        check("toe_trdy_after", {15'b0, readyfordata}, 16'h0001);
        cpu_read(3'd0, d);
        check("toe_rxdata", d, 16'h0055);

        // Frame aborted after 4 SCLK rises, then a clean frame.
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd1, 16'h00C7);
        SS_n = 1'b0;
        spi_xfer(8'hA0, 4, mi);
        check("abort_miso_bits", {8'h00, mi}, 16'h00C0);
        check("abort_oe_before", {15'b0, MISO_oe}, 16'h0001);
        SS_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_oe_released", {15'b0, MISO_oe}, 16'h0000);
        repeat (HALF) @(posedge clk);
        #1;
        check("abort_no_rrdy", {15'b0, dataavailable}, 16'h0000);
        cpu_write(3'd1, 16'h006B);
        frame1(8'hA9, mi);
        check("post_abort_miso", {8'h00, mi}, 16'h006B);
        cpu_read(3'd0, d);
        check("post_abort_rxdata", d, 16'h00A9);

        // Reset asserted in the middle of a frame.
        cpu_write(3'd1, 16'h00F0);
        SS_n = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        cpu_write(3'd1, 16'h0012);
        check("mid_miso", {15'b0, MISO}, 16'h0001);
        check("mid_oe", {15'b0, MISO_oe}, 16'h0001);
        check("mid_trdy", {15'b0, readyfordata}, 16'h0000);
        check("mid_irq", {15'b0, irq}, 16'h0001);
        #3 reset_n = 1'b0;
        #1;
        check("rst_mid_miso", {15'b0, MISO}, 16'h0000);
        check("rst_mid_oe", {15'b0, MISO_oe}, 16'h0000);
        check("rst_mid_irq", {15'b0, irq}, 16'h0000);
        check("rst_mid_trdy", {15'b0, readyfordata}, 16'h0001);
        SS_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        cpu_read(3'd2, d);
        check("rst_mid_status", d, 16'h0040);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
